// File: rtl/axi_dma_wdata.sv
// AXI write-data channel engine for a DMA: queues burst lengths, emits W beats, tracks B responses.
// Optional AXI_DMA_WDATA_BRESP_CHK_EN also flags non-OKAY responses and unexpected BID.
module axi_dma_wdata #(
  parameter int AXI_DW     = 128,
  parameter int AXI_LW     = 8,
  parameter int AXI_IW     = 12,
  parameter int AXI_BRESPW = 2,
  parameter int AXI_WSTRBW = AXI_DW / 8,
  parameter int OD         = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  desc_valid,
  input  logic [AXI_LW-1:0]     desc_len,
  output logic                  desc_ready,
  input  logic                  usr_wvalid,
  input  logic [AXI_DW-1:0]     usr_wdata,
  output logic                  usr_wready,
  output logic [AXI_DW-1:0]     axi_wdata,
  output logic [AXI_WSTRBW-1:0] axi_wstrb,
  output logic                  axi_wlast,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [AXI_IW-1:0]     axi_bid,
  input  logic [AXI_BRESPW-1:0] axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic                  w_idle,
  output logic                  w_err
);

  localparam int PW = $clog2(OD);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, DATA} state_t;

  state_t            state, state_nxt;
  logic [AXI_LW-1:0] fifo_mem [OD];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt, b_pend;
  logic [AXI_LW-1:0] beat_cnt;
  logic [CW:0]       used;
  logic              fifo_empty, fifo_full, push, pop;
  logic              usr_acc, last_beat, w_hs_last, b_hs, err_set;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CW'(OD));
  assign push       = desc_valid & ~fifo_full;
  assign usr_wready = (state == DATA) & (~axi_wvalid | axi_wready);
  assign usr_acc    = usr_wvalid & usr_wready;
  assign last_beat  = (beat_cnt == '0);
  assign w_hs_last  = axi_wvalid & axi_wready & axi_wlast;
  assign b_hs       = axi_bvalid;
  assign axi_bready = 1'b1;

  // Queued descriptors, the burst being streamed and unanswered bursts all count toward OD.
  assign used       = (CW+1)'(fifo_cnt) + (CW+1)'(state == DATA) + (CW+1)'(b_pend);
  assign desc_ready = (used < (CW+1)'(OD));
  assign w_idle     = (state == IDLE) & fifo_empty & ~axi_wvalid & (b_pend == '0);

`ifdef AXI_DMA_WDATA_BRESP_CHK_EN
  assign err_set = (b_hs & ~w_hs_last & (b_pend == '0)) |
                   (b_hs & ((axi_bresp != '0) | (axi_bid != AXI_IW'(1))));
`else
  logic unused_bchan;
  assign unused_bchan = ^{axi_bid, axi_bresp};
  assign err_set      = b_hs & ~w_hs_last & (b_pend == '0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // The next descriptor is popped on the last beat itself so bursts run without a bubble.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        state_nxt = DATA;
      end
      DATA: if (usr_acc && last_beat) begin
        if (!fifo_empty) pop       = 1'b1;
        else             state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= desc_len;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
      if (pop)                         beat_cnt <= fifo_mem[rd_ptr];
      else if (usr_acc && !last_beat)  beat_cnt <= beat_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      axi_wdata  <= '0;
      axi_wstrb  <= '0;
      axi_wlast  <= 1'b0;
      axi_wvalid <= 1'b0;
    end else if (usr_acc) begin
      axi_wdata  <= usr_wdata;
      axi_wstrb  <= '1;
      axi_wlast  <= last_beat;
      axi_wvalid <= 1'b1;
    end else if (axi_wready) begin
      axi_wvalid <= 1'b0;
    end
  end

  // A stray B with nothing outstanding is an error and must not underflow the counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_pend <= '0;
      w_err  <= 1'b0;
    end else begin
      if (w_hs_last && !b_hs)                   b_pend <= b_pend + 1'b1;
      else if (!w_hs_last && b_hs && b_pend != '0) b_pend <= b_pend - 1'b1;
      if (err_set) w_err <= 1'b1;
    end
  end

endmodule

// File: doc/axi_dma_wdata.md
AXI_DMA_WDATA -- requirements
Module: axi_dma_wdata

Interface
REQ-001 SHALL have parameter AXI_DW, default 128, W data width in bits.
REQ-002 SHALL have parameter AXI_LW, default 8, burst length field width.
REQ-003 SHALL have parameter AXI_IW, default 12, ID width.
REQ-004 SHALL have parameter AXI_BRESPW, default 2, BRESP width.
REQ-005 SHALL have parameter AXI_WSTRBW, default AXI_DW/8, strobe width.
REQ-006 SHALL have parameter OD, default 4, max outstanding bursts (power of 2, >=2).
REQ-007 SHALL have ports, in this order:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- desc_valid  in  1  AW handshake occurred (awvalid&awready)
- desc_len  in  AXI_LW  awlen of that burst
- desc_ready  out  1  may accept another burst descriptor
- usr_wvalid  in  1  user beat valid
- usr_wdata  in  AXI_DW  user beat data
- usr_wready  out  1  user beat accepted
- axi_wdata  out  AXI_DW  W data
- axi_wstrb  out  AXI_WSTRBW  W strobe
- axi_wlast  out  1  last beat of burst
- axi_wvalid  out  1  W valid
- axi_wready  in  1  W ready
- axi_bid  in  AXI_IW  B id
- axi_bresp  in  AXI_BRESPW  B response
- axi_bvalid  in  1  B valid
- axi_bready  out  1  B ready
- w_idle  out  1  nothing queued, in flight or awaiting B
- w_err  out  1  sticky response error

Function
REQ-008 SHALL hold descriptors (desc_len) in an OD-deep FIFO; push on desc_valid, ignored when full.
REQ-009 SHALL drive desc_ready=1 iff fifo_cnt + active_burst + b_pend < OD (active_burst = 1 in DATA).
REQ-010 SHALL implement FSM IDLE/DATA: IDLE->DATA when FIFO non-empty (pop, load beat_cnt=desc_len); DATA->IDLE on accepting last user beat unless FIFO non-empty, in which case pop next and stay DATA (no bubble).
REQ-011 SHALL register W outputs in a one-stage pipeline; usr_wready = (state==DATA) & (~axi_wvalid | axi_wready).
REQ-012 SHALL on user accept load axi_wdata=usr_wdata, axi_wstrb=all ones, axi_wlast=(beat_cnt==0), set axi_wvalid, decrement beat_cnt.
REQ-013 SHALL clear axi_wvalid on axi_wready with no new user accept in that cycle; hold all W outputs stable while axi_wvalid & ~axi_wready.
REQ-014 SHALL increment b_pend on axi_wvalid&axi_wready&axi_wlast, decrement on axi_bvalid&axi_bready; both together leave it unchanged.
REQ-015 SHALL drive axi_bready=1 constantly; B with b_pend==0 (and no same-cycle wlast handshake) SHALL set w_err and leave b_pend at 0.
REQ-016 SHALL ignore usr_wlast semantics: burst boundaries come only from desc_len.
REQ-017 SHALL drive w_idle = (state==IDLE) & FIFO empty & ~axi_wvalid & (b_pend==0).
REQ-018 SHALL size b_pend as $clog2(OD)+1 bits; desc_ready gating guarantees no overflow.

Reset
REQ-019 SHALL on reset_n low: FSM IDLE, FIFO empty, beat_cnt=0, b_pend=0, axi_wvalid=0, axi_wlast=0, axi_wdata=0, axi_wstrb=0, usr_wready=0, desc_ready=1, axi_bready=1, w_idle=1, w_err=0.
REQ-020 SHALL abandon any in-flight burst on reset mid-operation; no partial resume.

Configuration
REQ-021 SHALL, when AXI_DMA_WDATA_BRESP_CHK_EN is defined, also set w_err on any B handshake with axi_bresp!=0 or axi_bid!=1; w_err clears only by reset.
REQ-022 SHALL, without AXI_DMA_WDATA_BRESP_CHK_EN, ignore axi_bresp/axi_bid; w_err set only per REQ-015.

Verification
REQ-023 Single burst: desc_len=3, usr_wvalid=1, axi_wready=1 -> 4 W beats, wlast on 4th only, one B -> w_idle=1.
REQ-024 Back-to-back: push len 0 then len 1 -> beats 1,2,3 consecutive, wlast on beats 1 and 3, no idle cycle.
REQ-025 Backpressure: axi_wready=0 for 5 cycles mid-burst -> axi_wdata/wlast stable, usr_wready=0, no beat lost or duplicated.
REQ-026 Outstanding limit: OD=4, 4 bursts complete, no B returned -> desc_ready=0; one B -> desc_ready=1.
REQ-027 Simultaneous wlast handshake and B in same cycle with b_pend=1 -> b_pend stays 1.
REQ-028 With AXI_DMA_WDATA_BRESP_CHK_EN: B with bresp=2 -> w_err=1 next cycle, held until reset; without macro -> w_err=0.
